// File: rtl/spi_slave.sv
// SPI mode-0 responder with oversampled pins, one-deep TX buffer and RX holding register.
// Optional macro SPI_SLAVE_OVERRUN_EN: keep the unread word and flag rx_overrun instead of overwriting.
module spi_slave #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_avail,
  input  logic                  rx_rd,
  output logic                  rx_overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  state_t                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-2:0]   rx_shift_q;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [DATA_WIDTH-1:0]   tx_buf_q;
  logic                    tx_full_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    rx_avail_q;
  logic                    rx_overrun_q;
  logic                    miso_q;
  logic                    busy_q;

  logic                  sclk_s, cs_s, mosi_s;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_WIDTH-1:0] tx_next_d;
  logic [DATA_WIDTH-1:0] rx_word_d;
  logic [CNT_W-1:0]      miso_idx;

  // cs synchroniser resets high so an idle bus never looks like a select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign tx_next_d = tx_full_q ? tx_buf_q : FILL_BYTE;
  assign rx_word_d = {rx_shift_q, mosi_s};
  assign miso_idx  = LAST_BIT - bit_cnt_q;

  // Writes are refused while the next word's MSB is already previewed on miso
  assign tx_ready = ~tx_full_q & ~((state_q == ACTIVE) && (bit_cnt_q == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      tx_buf_q     <= '0;
      tx_full_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_avail_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;

      if (tx_wr && tx_ready) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end

      if (rx_rd && rx_avail_q) begin
        rx_avail_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ACTIVE;
            bit_cnt_q <= '0;
            miso_q    <= tx_next_d[DATA_WIDTH-1];
            busy_q    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_word_d[DATA_WIDTH-2:0];
            if (bit_cnt_q == '0) begin
              tx_shift_q <= tx_next_d;
              tx_full_q  <= 1'b0;
            end
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
`ifdef SPI_SLAVE_OVERRUN_EN
              if (rx_avail_q && !rx_rd) begin
                rx_overrun_q <= 1'b1;
              end else begin
                rx_data_q  <= rx_word_d;
                rx_avail_q <= 1'b1;
              end
`else
              rx_data_q  <= rx_word_d;
              rx_avail_q <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            miso_q <= (bit_cnt_q == '0) ? tx_next_d[DATA_WIDTH-1] : tx_shift_q[miso_idx];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso       = miso_q;
  assign rx_data    = rx_data_q;
  assign rx_avail   = rx_avail_q;
  assign rx_overrun = rx_overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bench-side SPI master (div 8) plus expected-value queues.
module tb_spi_slave;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, cs, mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_rd;
  logic       rx_overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  spi_slave dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_rd(rx_rd),
    .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    clks(1);
    tx_wr   = 1'b0;
  endtask

  task automatic read_rx();
    rx_rd = 1'b1;
    clks(1);
    rx_rd = 1'b0;
    clks(1);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    clks(HALF);
  endtask

  task automatic cs_high();
    clks(HALF);
    cs = 1'b1;
    clks(2 * HALF);
  endtask

  // Master shifts n bits MSB-first, sampling miso on each sclk rise
  task automatic shift_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      clks(HALF);
      sclk = 1'b1;
      rx[7-i] = miso;
      clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    cs_low();
    shift_bits(tx, 8, rx);
    cs_high();
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0;
    clks(3);
    exp = 8'h00;
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL reset_rx_data: got %h expected %h", rx_data, exp); end
    n_checks++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL reset_rx_avail: got %b expected 0", rx_avail); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    clks(5);
  endtask

  task automatic test_basic();
    logic [7:0] got, exp;
    write_tx(8'h5C);
    exp_miso_q.push_back(8'h5C);
    write_tx(8'h99);  // tx_ready is low here, so this write must be dropped
    exp_rx_q.push_back(8'hA3);
    cs_low();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_on: got %b expected 1", busy); end
    shift_bits(8'hA3, 8, got);
    cs_high();
    exp = exp_miso_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL basic_master_rx: got %h expected %h", got, exp); end
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL basic_rx_data: got %h expected %h", rx_data, exp); end
    n_checks++; if (rx_avail !== 1'b1) begin n_fail++; $display("FAIL basic_rx_avail: got %b expected 1", rx_avail); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_tx_ready: got %b expected 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_off: got %b expected 0", busy); end
    read_rx();
    n_checks++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL basic_rd_clear: got %b expected 0", rx_avail); end
  endtask

  task automatic test_fill();
    logic [7:0] got, exp;
    exp_miso_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h00);
    xfer(8'h00, got);
    exp = exp_miso_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL fill_master_rx: got %h expected %h", got, exp); end
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL fill_rx_data: got %h expected %h", rx_data, exp); end
    read_rx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    write_tx(8'h11);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(8'h22);
    exp_rx_q.push_back(8'h3C);
    exp_rx_q.push_back(8'hC3);
    cs_low();
    fork
      shift_bits(8'h3C, 8, got);
      begin
        for (int i = 0; i < 200 && tx_ready !== 1'b1; i++) clks(1);
        n_checks++;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL burst_tx_ready_wait: got %b expected 1", tx_ready); end
        else write_tx(8'h22);
      end
    join
    exp = exp_miso_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL burst_master_rx0: got %h expected %h", got, exp); end
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL burst_rx_data0: got %h expected %h", rx_data, exp); end
    read_rx();
    shift_bits(8'hC3, 8, got);
    cs_high();
    exp = exp_miso_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL burst_master_rx1: got %h expected %h", got, exp); end
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL burst_rx_data1: got %h expected %h", rx_data, exp); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL burst_overrun: got %b expected 0", rx_overrun); end
    read_rx();
  endtask

  task automatic test_abort();
    logic [7:0] got, exp;
    cs_low();
    shift_bits(8'hF0, 4, got);
    cs_high();
    n_checks++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL abort_rx_avail: got %b expected 0", rx_avail); end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso: got %b expected 0", miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    exp_rx_q.push_back(8'h96);
    xfer(8'h96, got);
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL abort_next_rx: got %h expected %h", rx_data, exp); end
    n_checks++; if (rx_avail !== 1'b1) begin n_fail++; $display("FAIL abort_next_avail: got %b expected 1", rx_avail); end
    read_rx();
  endtask

  task automatic test_overrun();
    logic [7:0] got, exp;
    logic       exp_ovr;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_rx_q.push_back(8'hAA);
    exp_ovr = 1'b1;
`else
    exp_rx_q.push_back(8'h55);
    exp_ovr = 1'b0;
`endif
    xfer(8'hAA, got);
    xfer(8'h55, got);
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL overrun_rx_data: got %h expected %h", rx_data, exp); end
    n_checks++; if (rx_overrun !== exp_ovr) begin n_fail++; $display("FAIL overrun_flag: got %b expected %b", rx_overrun, exp_ovr); end
    read_rx();
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", rx_overrun); end
    n_checks++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL overrun_avail_clear: got %b expected 0", rx_avail); end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] got, exp;
    xfer(8'h81, got);
    cs_low();
    shift_bits(8'hF0, 3, got);
    write_tx(8'h77);
    reset = 1'b1;
    clks(1);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL mid_reset_miso: got %b expected 0", miso); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rx_avail: got %b expected 0", rx_avail); end
    n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun: got %b expected 0", rx_overrun); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_tx_ready: got %b expected 1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    cs = 1'b1;
    clks(2);
    reset = 1'b0;
    clks(6);
    exp_miso_q.push_back(8'hFF);  // reset emptied the TX buffer holding 0x77
    exp_rx_q.push_back(8'hC5);
    xfer(8'hC5, got);
    exp = exp_miso_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL mid_after_master_rx: got %h expected %h", got, exp); end
    exp = exp_rx_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL mid_after_rx_data: got %h expected %h", rx_data, exp); end
    n_checks++; if (rx_avail !== 1'b1) begin n_fail++; $display("FAIL mid_after_rx_avail: got %b expected 1", rx_avail); end
    read_rx();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_midbyte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
